// File: rtl/prbs_checker.sv
// PRBS checker: searches for a PRBS7/15/23/31 sequence in a byte stream,
// locks a local generator to it and counts bit errors while locked.
// Bits are handled MSB first; history bit 0 is the most recently received bit.
module prbs_checker #(
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_BITS = 4,
  parameter int LOSS_CNT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  poly_sel,
  input  logic        in_valid,
  input  logic [7:0]  rx_data,
  input  logic        clr_counts,
  output logic        locked,
  output logic [7:0]  err_mask,
  output logic        err_valid,
  output logic [31:0] err_count,
  output logic [31:0] bit_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t      state;
  logic [30:0] hist;
  logic [30:0] lfsr;
  logic [1:0]  poly_q;
  logic [2:0]  fill;
  logic [15:0] clean_cnt;
  logic [15:0] bad_cnt;

  logic [4:0]  tap_a;
  logic [4:0]  tap_b;
  logic [30:0] hist_nxt;
  logic [30:0] lfsr_nxt;
  logic [7:0]  mask_nxt;
  logic        exp_bit;
  logic [3:0]  err_bits;
  logic        clean_byte;
  logic        bad_byte;
  logic        poly_changed;

  // Saturating add for the 32-bit statistics counters.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Tap positions (history index of s[n-a] and s[n-b]) for the selected polynomial.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (latch).
    tap_a = 5'd6;
    tap_b = 5'd5;
    case (poly_sel)
      2'd0:    begin tap_a = 5'd6;  tap_b = 5'd5;  end
      2'd1:    begin tap_a = 5'd14; tap_b = 5'd13; end
      2'd2:    begin tap_a = 5'd22; tap_b = 5'd17; end
      default: begin tap_a = 5'd30; tap_b = 5'd27; end
    endcase
  end

  // Walk the byte bit 7 first: predict each bit, record the mismatch, shift it into history.
  always_comb begin
    hist_nxt = hist;
    lfsr_nxt = lfsr;
    mask_nxt = '0;
    exp_bit  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      // NOTE: blocking assignments here chain each bit's result into the next iteration.
      if (state == LOCKED) begin
        exp_bit  = lfsr_nxt[tap_a] ^ lfsr_nxt[tap_b];
        lfsr_nxt = {lfsr_nxt[29:0], exp_bit};
      end else begin
        exp_bit  = hist_nxt[tap_a] ^ hist_nxt[tap_b];
      end
      mask_nxt[i] = rx_data[i] ^ exp_bit;
      hist_nxt    = {hist_nxt[29:0], rx_data[i]};
    end
  end

  // Byte classification: error popcount, clean (search) and bad (locked) qualifiers.
  always_comb begin
    err_bits = '0;
    for (int i = 0; i < 8; i++) begin
      err_bits = err_bits + 4'(mask_nxt[i]);
    end
    clean_byte   = (fill == 3'd4) && (err_bits == 4'd0) && (hist != '0);
    bad_byte     = int'(err_bits) >= LOSS_BITS;
    poly_changed = (poly_sel != poly_q);
  end

  // Lock FSM with history, local generator, fill/clean/bad counters and error mask.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state     <= SEARCH;
      hist      <= '0;
      lfsr      <= '0;
      fill      <= '0;
      clean_cnt <= '0;
      bad_cnt   <= '0;
      poly_q    <= poly_sel;
      err_mask  <= '0;
      err_valid <= 1'b0;
    end else begin
      poly_q    <= poly_sel;
      err_valid <= in_valid;
      if (in_valid) begin
        err_mask <= mask_nxt;
        hist     <= hist_nxt;
        if (state == SEARCH) begin
          fill <= (fill == 3'd4) ? fill : fill + 3'd1;
          if (!clean_byte) begin
            clean_cnt <= '0;
          end else if (clean_cnt + 16'd1 == 16'(LOCK_CNT)) begin
            // Seed the generator from history including the byte just received.
            state     <= LOCKED;
            lfsr      <= hist_nxt;
            clean_cnt <= '0;
            bad_cnt   <= '0;
          end else begin
            clean_cnt <= clean_cnt + 16'd1;
          end
        end else begin
          lfsr <= lfsr_nxt;
          if (!bad_byte) begin
            bad_cnt <= '0;
          end else if (bad_cnt + 16'd1 == 16'(LOSS_CNT)) begin
            state     <= SEARCH;
            fill      <= '0;
            clean_cnt <= '0;
            bad_cnt   <= '0;
          end else begin
            bad_cnt <= bad_cnt + 16'd1;
          end
        end
      end
      // A polynomial change restarts the search regardless of the current byte.
      if (poly_changed) begin
        state     <= SEARCH;
        fill      <= '0;
        clean_cnt <= '0;
        bad_cnt   <= '0;
      end
    end
  end

  // Error and bit statistics, counted only for bytes checked while locked; clear wins.
  always_ff @(posedge clock) begin
    if (reset || clr_counts) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (in_valid && state == LOCKED) begin
      err_count <= sat_add(err_count, {28'd0, err_bits});
      bit_count <= sat_add(bit_count, 32'd8);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus randomized
// streams with injected errors, compared against a bit-sequence reference model.
module tb_prbs_checker;

  localparam int LOCK_CNT  = 4;
  localparam int LOSS_BITS = 4;
  localparam int LOSS_CNT  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  poly_sel = 2'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_counts = 1'b0;
  logic        locked;
  logic [7:0]  err_mask;
  logic        err_valid;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_BITS(LOSS_BITS), .LOSS_CNT(LOSS_CNT)) dut (
    .clock(clk), .reset(reset), .poly_sel(poly_sel), .in_valid(in_valid),
    .rx_data(rx_data), .clr_counts(clr_counts), .locked(locked),
    .err_mask(err_mask), .err_valid(err_valid), .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: explicit bit sequences ----------------
  bit              hq[$];   // received bits, oldest first
  bit              gq[$];   // bits produced by the locked generator
  bit              m_locked;
  int              m_fill, m_clean, m_bad;
  longint unsigned m_err, m_bits;
  logic [7:0]      m_mask;
  bit              m_ev;
  logic [1:0]      m_poly;

  function automatic int tap_a(input int p);
    case (p)
      0: return 7;
      1: return 15;
      2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tap_b(input int p);
    case (p)
      0: return 6;
      1: return 14;
      2: return 18;
      default: return 28;
    endcase
  endfunction

  task automatic model_reset(input logic [1:0] p);
    hq.delete();
    gq.delete();
    repeat (31) hq.push_back(1'b0);
    m_locked = 0; m_fill = 0; m_clean = 0; m_bad = 0;
    m_err = 0; m_bits = 0; m_mask = 8'h00; m_ev = 0; m_poly = p;
  endtask

  task automatic model_byte(input logic [7:0] d, input bit clr, input int p);
    int a, b, n, pc;
    bit prior_nz, e, cl;
    logic [7:0] mask;
    a = tap_a(p);
    b = tap_b(p);
    prior_nz = 0;
    for (int k = 1; k <= 31; k++) if (hq[hq.size() - k]) prior_nz = 1;
    mask = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (m_locked) begin
        n = gq.size();
        e = gq[n - a] ^ gq[n - b];
        gq.push_back(e);
      end else begin
        n = hq.size();
        e = hq[n - a] ^ hq[n - b];
      end
      mask[i] = d[i] ^ e;
      hq.push_back(d[i]);
    end
    while (hq.size() > 64) void'(hq.pop_front());
    while (gq.size() > 64) void'(gq.pop_front());
    pc = $countones(mask);
    if (m_locked) begin
      m_err  = m_err + pc;
      m_bits = m_bits + 8;
      if (m_err  > 64'hFFFF_FFFF) m_err  = 64'hFFFF_FFFF;
      if (m_bits > 64'hFFFF_FFFF) m_bits = 64'hFFFF_FFFF;
    end
    if (clr) begin m_err = 0; m_bits = 0; end
    if (!m_locked) begin
      cl = (m_fill == 4) && (pc == 0) && prior_nz;
      if (m_fill < 4) m_fill++;
      m_clean = cl ? m_clean + 1 : 0;
      if (m_clean == LOCK_CNT) begin
        m_locked = 1; m_clean = 0; m_bad = 0;
        gq = hq;
      end
    end else begin
      m_bad = (pc >= LOSS_BITS) ? m_bad + 1 : 0;
      if (m_bad == LOSS_CNT) begin
        m_locked = 0; m_fill = 0; m_clean = 0; m_bad = 0;
      end
    end
    m_mask = mask;
    m_ev   = 1;
  endtask

  // ---------------- PRBS source ----------------
  bit sq[$];
  int src_p;

  task automatic src_seed(input int p);
    sq.delete();
    src_p = p;
    repeat (tap_a(p)) sq.push_back(1'b1);
  endtask

  task automatic src_byte(output logic [7:0] d);
    int n;
    for (int i = 7; i >= 0; i--) begin
      n = sq.size();
      d[i] = sq[n - tap_a(src_p)] ^ sq[n - tap_b(src_p)];
      sq.push_back(d[i]);
    end
    while (sq.size() > 64) void'(sq.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit v, input logic [7:0] d, input bit c);
    in_valid = v; rx_data = d; clr_counts = c;
    if (v) model_byte(d, c, int'(poly_sel));
    else begin
      m_ev = 0;
      if (c) begin m_err = 0; m_bits = 0; end
    end
    if (poly_sel != m_poly) begin
      m_locked = 0; m_fill = 0; m_clean = 0; m_bad = 0;
    end
    m_poly = poly_sel;
    @(posedge clk);
    #1;
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("err_valid", {31'd0, err_valid}, {31'd0, m_ev});
    check("err_mask", {24'd0, err_mask}, {24'd0, m_mask});
    check("err_count", err_count, m_err[31:0]);
    check("bit_count", bit_count, m_bits[31:0]);
    in_valid = 1'b0; clr_counts = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] p);
    poly_sel = p; reset = 1'b1; in_valid = 1'b0; clr_counts = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset(p);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_mask", {24'd0, err_mask}, 32'd0);
    check("rst_err_count", err_count, 32'd0);
    check("rst_bit_count", bit_count, 32'd0);
  endtask

  task automatic set_poly(input logic [1:0] p);
    poly_sel = p;
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_src(input logic [7:0] flip, input bit c);
    logic [7:0] d;
    src_byte(d);
    cycle(1'b1, d ^ flip, c);
  endtask

  initial begin
    logic [7:0] d;
    int r;

    // Clean PRBS7 from seed 7F: lock one cycle after byte 8, then 8 bits per byte.
    do_reset(2'd0);
    src_seed(0);
    for (int k = 1; k <= 20; k++) begin
      send_src(8'h00, 1'b0);
      check("prbs7_lock_at_8", {31'd0, locked}, {31'd0, k >= 8});
      if (k >= 8) begin
        check("prbs7_bit_count", bit_count, 32'(8 * (k - 8)));
        check("prbs7_err_count", err_count, 32'd0);
      end
    end

    // PRBS31 lock, then a single flipped bit 3.
    set_poly(2'd3);
    check("poly_change_unlocks", {31'd0, locked}, 32'd0);
    src_seed(3);
    for (int k = 1; k <= 10; k++) send_src(8'h00, 1'b0);
    check("prbs31_locked", {31'd0, locked}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    send_src(8'h08, 1'b0);
    check("flip_mask", {24'd0, err_mask}, 32'h08);
    check("flip_err_count", err_count, 32'd1);
    check("flip_locked", {31'd0, locked}, 32'd1);
    send_src(8'h00, 1'b0);
    check("after_flip_mask", {24'd0, err_mask}, 32'h00);
    check("after_flip_err_count", err_count, 32'd1);
    check("after_flip_bit_count", bit_count, 32'd16);

    // Three all-ones bytes replacing the stream, then recovery.
    for (int j = 0; j < 3; j++) begin
      src_byte(d);
      cycle(1'b1, 8'hFF, 1'b0);
    end
    for (int k = 1; k <= 10; k++) send_src(8'h00, 1'b0);
    check("relock_after_ones", {31'd0, locked}, 32'd1);

    // Three fully inverted bytes: lock drops exactly after the third, relock after 8.
    cycle(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < 3; j++) begin
      send_src(8'hFF, 1'b0);
      check("loss_locked", {31'd0, locked}, {31'd0, j < 2});
      check("loss_err_count", err_count, 32'(8 * (j + 1)));
      check("loss_bit_count", bit_count, 32'(8 * (j + 1)));
    end
    for (int k = 1; k <= 8; k++) begin
      send_src(8'h00, 1'b0);
      check("relock_at_8", {31'd0, locked}, {31'd0, k >= 8});
    end

    // clr_counts coinciding with an errored locked byte.
    send_src(8'h00, 1'b0);
    send_src(8'hFF, 1'b1);
    check("clr_err_count", err_count, 32'd0);
    check("clr_bit_count", bit_count, 32'd0);
    check("clr_mask", {24'd0, err_mask}, 32'hFF);

    // All-zero input never locks.
    do_reset(2'd0);
    for (int k = 0; k < 100; k++) begin
      cycle(1'b1, 8'h00, 1'b0);
      check("zeros_no_lock", {31'd0, locked}, 32'd0);
    end
    check("zeros_err_count", err_count, 32'd0);

    // PRBS15 with idle gaps locks at the same byte, then reset mid-lock.
    do_reset(2'd1);
    src_seed(1);
    for (int k = 1; k <= 12; k++) begin
      send_src(8'h00, 1'b0);
      check("gap_lock_at_8", {31'd0, locked}, {31'd0, k >= 8});
      cycle(1'b0, 8'h5A, 1'b0);
      check("gap_hold", {31'd0, locked}, {31'd0, k >= 8});
      check("gap_no_valid", {31'd0, err_valid}, 32'd0);
    end
    check("gap_bit_count", bit_count, 32'd32);
    in_valid = 1'b1; clr_counts = 1'b1;
    do_reset(2'd1);

    // Randomized streams with error injection, idle gaps and clears.
    for (int seg = 0; seg < 4; seg++) begin
      r = int'($urandom_range(3));
      if (seg % 2 == 0) do_reset(2'(r));
      else set_poly(2'(r));
      src_seed(r);
      for (int c = 0; c < 700; c++) begin
        r = int'($urandom_range(99));
        if (r < 20) cycle(1'b0, 8'($urandom), ($urandom_range(49) == 0));
        else if (r < 97) begin
          r = int'($urandom_range(99));
          if (r < 85)      send_src(8'h00, ($urandom_range(99) == 0));
          else if (r < 93) send_src(8'(1 << $urandom_range(7)), 1'b0);
          else             send_src(8'($urandom), 1'b0);
        end else begin
          for (int j = 0; j < 4; j++) send_src(8'hFF, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
